// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, one-outstanding imem fetch, single-entry slot to decode.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic [1:0]  bubble,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [1:0]  bubble_cnt;
    logic        hold;
    logic        advance;
    logic        slot_free;
    logic        req_fire;
    logic        capture;
    logic        unused;

    assign unused    = ^redirect_pc[1:0];
    assign hold      = stall | (valid_q & ((bubble_cnt != 2'd0) | (bubble != 2'd0)));
    assign advance   = valid_q & ~hold;
    assign slot_free = ~valid_q | advance;
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign capture   = (state == S_WAIT) & imem_resp_valid & ~redirect_valid;

    assign imem_addr   = pc;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? instr_q : NOP_INSTR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    // A response still in flight at redirect time belongs to a flushed PC.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_nx = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_nx = S_REQ;
                end else if (redirect_valid) begin
                    state_nx = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (state == S_REQ) begin
            imem_req_valid = rst_n & slot_free & ~stall & ~redirect_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc   <= 32'd0;
            valid_q    <= 1'b0;
            bubble_cnt <= 2'd0;
        end else if (redirect_valid) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            valid_q    <= 1'b0;
            bubble_cnt <= 2'd0;
        end else begin
            if (capture) begin
                instr_q  <= imem_resp_data;
                instr_pc <= pc;
                valid_q  <= 1'b1;
                pc       <= pc + 32'd4;
            end else if (advance) begin
                valid_q <= 1'b0;
            end
            // Counter holds bubble-1 so the slot stays put exactly `bubble` cycles.
            if (!stall) begin
                if (bubble_cnt != 2'd0) begin
                    bubble_cnt <= bubble_cnt - 2'd1;
                end else if (valid_q && (bubble != 2'd0)) begin
                    bubble_cnt <= bubble - 2'd1;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bub_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            bub_cnt_q   <= 32'd0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_q & ~stall & ((bubble != 2'd0) | (bubble_cnt != 2'd0))) begin
                bub_cnt_q <= bub_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bub_cnt_q;
`else
    assign perf_fetch_cnt  = 32'd0;
    assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random stimulus against a transaction-level fetch model.
// Reference model tracks the outstanding fetch as live/flushed and the slot's remaining hold.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int NONE    = 0;
    localparam int LIVE    = 1;
    localparam int FLUSHED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic [1:0]  bubble = 2'd0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .bubble          (bubble),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_ipc = 32'd0;
    bit          m_valid = 1'b0;
    int          m_hold = 0;
    int          m_out = NONE;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_bub = 32'd0;
    int          rtimer = 0;
    logic [31:0] raddr = 32'd0;
    int          lat_cfg = 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rdy, input bit stl, input logic [1:0] bub,
                        input bit rd, input logic [31:0] rpc);
        bit          hold;
        bit          adv;
        bit          slot_free;
        bit          exp_req;
        bit          fire;
        bit          resp;
        bit          cap;
        logic [31:0] a0;
        a0 = m_pc;
        imem_req_ready = rdy;
        stall = stl;
        bubble = bub;
        redirect_valid = rd;
        redirect_pc = rpc;
        resp = (rtimer == 1);
        imem_resp_valid = resp;
        imem_resp_data = resp ? memf(raddr) : $urandom;
        hold = stl | (m_valid & ((m_hold != 0) | (bub != 2'd0)));
        adv = m_valid & ~hold;
        slot_free = ~m_valid | adv;
        exp_req = (m_out == NONE) & slot_free & ~stl & ~rd;
        fire = exp_req & rdy;
        cap = resp & (m_out == LIVE) & ~rd;
        @(negedge clk);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_valid ? m_instr : NOP);
        if (m_valid) chk("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_bubble", perf_bubble_cnt, m_bub);
`else
        chk("perf_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        if (cap) m_fetch++;
        if (m_valid && !stl && (bub != 2'd0 || m_hold != 0)) m_bub++;
        if (rd) begin
            m_valid = 1'b0;
            m_hold = 0;
            m_pc = {rpc[31:2], 2'b00};
            if (resp) m_out = NONE;
            else if (m_out != NONE) m_out = FLUSHED;
        end else begin
            if (!stl) begin
                if (m_hold > 0) m_hold--;
                else if (m_valid && bub != 2'd0) m_hold = int'(bub) - 1;
            end
            if (cap) begin
                m_valid = 1'b1;
                m_instr = memf(raddr);
                m_ipc = a0;
                m_pc = a0 + 32'd4;
                m_out = NONE;
            end else if (adv) begin
                m_valid = 1'b0;
            end
            if (resp && m_out == FLUSHED) m_out = NONE;
        end
        if (resp) rtimer = 0;
        else if (rtimer > 1) rtimer--;
        if (fire) begin
            m_out = LIVE;
            raddr = a0;
            rtimer = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_bubble", perf_bubble_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat_cfg = 1;
        repeat (6) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        for (int i = 0; i < 8 && !m_valid; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 2'd2, 1'b0, 32'd0);
        repeat (5) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        repeat (3) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        lat_cfg = 3;
        for (int i = 0; i < 8 && m_out != LIVE; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_3002);
        repeat (10) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        lat_cfg = 2;
        for (int i = 0; i < 8 && m_out != LIVE; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        repeat (4) step(1'b1, 1'b1, 2'd0, 1'b0, 32'd0);
        repeat (6) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        lat_cfg = 1;
        for (int i = 0; i < 8 && m_out != LIVE; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_4001);
        repeat (6) step(1'b1, 1'b0, 2'd0, 1'b0, 32'd0);

        lat_cfg = 0;
        repeat (3000) begin
            step(($urandom % 4) != 0, ($urandom % 8) == 0,
                 (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 ($urandom % 12) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/register-read stage.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request and valid-only response.
- Presents a single buffered instruction plus its PC to decode.
- Holds that instruction for the number of bubble cycles decode requests, and flushes on branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_2000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven while instr_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_addr  out  32  fetch address (word aligned).
- imem_resp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle later).
- imem_resp_data  in  32  fetched instruction word.
- bubble  in  2  decode's stall request: number of cycles to hold current instruction (0–3).
- stall  in  1  global back-end stall; hold everything except an outstanding response capture.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  redirect target.
- instr  out  32  instruction to decode (NOP_INSTR when instr_valid=0).
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr slot holds a live instruction.
- perf_fetch_cnt  out  32  see Optional Feature.
- perf_bubble_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ, instr_valid=0, instr=NOP_INSTR, instr_pc=0.
  - bubble_cnt=0, imem_req_valid=0, perf counters=0.
  - First request is issued in the first cycle after rst_n deasserts.
- Definitions:
  - hold = stall | (instr_valid & (bubble_cnt!=0 | bubble!=0)).
  - advance = instr_valid & ~hold.
  - slot_free = ~instr_valid | advance.
- Bubble counter, evaluated only when ~stall & ~redirect_valid:
  - If bubble_cnt==0 and instr_valid and bubble!=0: load bubble_cnt = bubble-1.
  - If bubble_cnt!=0: decrement; the bubble input is ignored while counting.
  - Net effect: the instruction is held for exactly `bubble` cycles, then advances.
- FSM states:
  - REQ: imem_req_valid=1 iff slot_free & ~stall & ~redirect_valid; imem_addr=pc. On valid&ready go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid: instr=resp_data, instr_pc=pc, instr_valid=1, pc=pc+4 (mod 2^32), go to REQ. The response is captured even under stall, because the slot was free when the request was issued.
  - DROP: the outstanding response belongs to a flushed PC. On imem_resp_valid, discard the data and go to REQ.
- advance with no new instruction captured the same cycle: instr_valid=0 next cycle.
- Redirect (highest priority, any state, overrides stall and bubble):
  - Next cycle: instr_valid=0, bubble_cnt=0, pc = {redirect_pc[31:2],2'b00}.
  - If in WAIT and resp_valid is not present that cycle: go to DROP.
  - If resp_valid coincides with redirect: discard the data, go to REQ.
  - If in DROP: remain in DROP.
  - No request is issued in the redirect cycle.
- Redirect arriving while a request handshake completes in the same cycle: that request is treated as outstanding and the FSM goes to DROP.
- Only one request is ever outstanding. imem_addr is stable while imem_req_valid=1 and ready=0.
- Back-to-back redirects: the last one wins; DROP still discards exactly one response.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on every instruction captured into the slot (excluding dropped responses).
  - perf_bubble_cnt increments on every cycle where instr_valid & ~stall & (bubble!=0 | bubble_cnt!=0).
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter flops exist.

Test Plan:
- Reset release, imem ready=1, resp 1 cycle after request, bubble=0 → requests at 0x2000, 0x2004, 0x2008; instr_pc follows; instr_valid high from cycle 3 onward.
- Instruction at 0x2004 valid, bubble=2 for one cycle → instr/instr_pc held exactly 2 cycles, then advances to 0x2008; no request issued while the slot is full. Under FETCH_PERF_EN, perf_bubble_cnt=2.
- imem_req_ready low for 3 cycles → imem_addr and imem_req_valid stable throughout; a single request is accepted on the 4th cycle.
- Redirect to 0x3002 while in WAIT, response arrives 2 cycles later → response discarded, next request addr=0x3000, instr_valid=0 until 0x3000 returns.
- stall=1 for 4 cycles with an outstanding request → response captured, no further request issued, instr held; fetch resumes the cycle after stall drops.
- redirect_valid and imem_resp_valid in the same cycle → data discarded, FSM returns to REQ, next imem_addr=redirect target; perf_fetch_cnt does not increment.
